// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared fetch-stage definitions: FSM encoding, reset PC, NOP encoding
package if_stage_pkg;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } if_state_e;

    localparam logic [63:0] IF_RESET_PC = 64'h0000_0000_8000_0000;
    localparam logic [31:0] IF_NOP      = 32'h0000_0013;

endpackage

// File: rtl/if_pc_reg.sv
// rtl/if_pc_reg.sv - fetch PC and stored redirect target registers
module if_pc_reg
    import if_stage_pkg::*;
#(
    parameter logic [63:0] RESET_PC = IF_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_load,
    input  logic [63:0] pc_next,
    input  logic        tgt_load,
    input  logic [63:0] tgt_next,
    output logic [63:0] fetch_pc,
    output logic [63:0] tgt_pc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            tgt_pc   <= '0;
        end else begin
            if (pc_load)
                fetch_pc <= pc_next;
            if (tgt_load)
                tgt_pc <= tgt_next;
        end
    end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage; IF_PERF_CNT_EN enables fetch/flush counters
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [63:0] RESET_PC = IF_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_ena_if,
    input  logic [63:0] pc_if,
    output logic        imem_req_valid,
    output logic [63:0] imem_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [63:0] inst_pc,
    input  logic        inst_ready,
    output logic [63:0] fetch_cnt,
    output logic [63:0] flush_cnt
);

    if_state_e   state;
    if_state_e   state_nxt;
    logic        kill;
    logic        active;
    logic [63:0] fetch_pc;
    logic [63:0] tgt_pc;
    logic        pc_load;
    logic [63:0] pc_next;
    logic        req_fire;
    logic        rsp_take;
    logic        rsp_drop;
    logic        hold_accept;

    assign req_fire    = imem_req_valid && imem_req_ready;
    assign rsp_take    = (state == ST_WAIT) && imem_rsp_valid;
    assign rsp_drop    = kill || pc_ena_if;
    assign hold_accept = (state == ST_HOLD) && inst_ready;
    assign imem_addr   = fetch_pc;

    if_pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .pc_load  (pc_load),
        .pc_next  (pc_next),
        .tgt_load (pc_ena_if),
        .tgt_next (pc_if),
        .fetch_pc (fetch_pc),
        .tgt_pc   (tgt_pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_REQ;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_REQ:  if (req_fire) state_nxt = ST_WAIT;
            ST_WAIT: if (imem_rsp_valid) state_nxt = rsp_drop ? ST_REQ : ST_HOLD;
            ST_HOLD: if (pc_ena_if || inst_ready) state_nxt = ST_REQ;
            default: state_nxt = ST_REQ;
        endcase
    end

    // Requests stay off until the first edge after reset release.
    always_comb begin
        imem_req_valid = (state == ST_REQ) && active;
        inst_valid     = (state == ST_HOLD);
    end

    always_comb begin
        pc_load = 1'b0;
        pc_next = fetch_pc;
        if (rsp_take && pc_ena_if) begin
            pc_load = 1'b1;
            pc_next = pc_if;
        end else if (rsp_take && kill) begin
            pc_load = 1'b1;
            pc_next = tgt_pc;
        end else if ((state == ST_HOLD) && pc_ena_if) begin
            pc_load = 1'b1;
            pc_next = pc_if;
        end else if (hold_accept) begin
            pc_load = 1'b1;
            pc_next = inst_pc + 64'd4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active  <= 1'b0;
            kill    <= 1'b0;
            inst    <= IF_NOP;
            inst_pc <= '0;
        end else begin
            active <= 1'b1;
            if (rsp_take)
                kill <= 1'b0;
            else if (pc_ena_if && (state != ST_HOLD))
                kill <= 1'b1;
            if (rsp_take && !rsp_drop) begin
                inst    <= imem_rsp_data;
                inst_pc <= fetch_pc;
            end
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (hold_accept)
                fetch_cnt <= fetch_cnt + 64'd1;
            if (pc_ena_if)
                flush_cnt <= flush_cnt + 64'd1;
        end
    end
`else
    assign fetch_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed self-checking bench for if_stage
module tb_if_stage;

    logic        clk;
    logic        rst_n;
    logic        pc_ena_if;
    logic [63:0] pc_if;
    logic        imem_req_valid;
    logic [63:0] imem_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        inst_ready;
    logic [63:0] fetch_cnt;
    logic [63:0] flush_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    bit auto_mem;

    if_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc_ena_if      (pc_ena_if),
        .pc_if          (pc_if),
        .imem_req_valid (imem_req_valid),
        .imem_addr      (imem_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .fetch_cnt      (fetch_cnt),
        .flush_cnt      (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock; the memory model answers an accepted request in the next cycle.
    task automatic cyc();
        logic        fire;
        logic [63:0] a;
        fire = imem_req_valid && imem_req_ready;
        a    = imem_addr;
        @(posedge clk);
        #1;
        if (auto_mem) begin
            imem_rsp_valid = fire;
            imem_rsp_data  = a[31:0] | 32'h0000_0013;
        end
        #1;
    endtask

    task automatic to_hold(input logic [63:0] a, input logic [31:0] d);
        chk1("req_valid", imem_req_valid, 1'b1);
        chk64("req_addr", imem_addr, a);
        cyc();
        chk1("wait_no_inst", inst_valid, 1'b0);
        cyc();
        chk1("hold_valid", inst_valid, 1'b1);
        chk32("hold_inst", inst, d);
        chk64("hold_inst_pc", inst_pc, a);
    endtask

    initial begin
        rst_n          = 1'b0;
        pc_ena_if      = 1'b0;
        pc_if          = '0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        inst_ready     = 1'b0;
        auto_mem       = 1'b1;

        repeat (2) @(posedge clk);
        #2;
        chk1("rst_req_valid", imem_req_valid, 1'b0);
        chk1("rst_inst_valid", inst_valid, 1'b0);
        chk32("rst_inst", inst, 32'h0000_0013);
        chk64("rst_inst_pc", inst_pc, 64'h0);
        chk64("rst_addr", imem_addr, 64'h0000_0000_8000_0000);
        chk64("rst_fetch_cnt", fetch_cnt, 64'h0);
        chk64("rst_flush_cnt", flush_cnt, 64'h0);

        rst_n = 1'b1;
        #1;
        chk1("release_idle", imem_req_valid, 1'b0);
        cyc();
        chk1("first_req", imem_req_valid, 1'b1);
        chk64("first_addr", imem_addr, 64'h0000_0000_8000_0000);

        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        to_hold(64'h0000_0000_8000_0000, 32'h8000_0013); cyc();
        to_hold(64'h0000_0000_8000_0004, 32'h8000_0017); cyc();
        to_hold(64'h0000_0000_8000_0008, 32'h8000_001B); cyc();

        inst_ready = 1'b0;
        to_hold(64'h0000_0000_8000_000C, 32'h8000_001F);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk1("stall_valid", inst_valid, 1'b1);
            chk32("stall_inst", inst, 32'h8000_001F);
            chk64("stall_inst_pc", inst_pc, 64'h0000_0000_8000_000C);
            chk1("stall_no_req", imem_req_valid, 1'b0);
        end
        inst_ready = 1'b1;
        cyc();
        chk64("after_stall_addr", imem_addr, 64'h0000_0000_8000_0010);

        auto_mem = 1'b0;
        cyc();
        chk1("wait_no_req", imem_req_valid, 1'b0);
        pc_ena_if = 1'b1;
        pc_if     = 64'h0000_0000_8000_0100;
        cyc();
        pc_ena_if = 1'b0;
        chk1("wait_redir_no_inst", inst_valid, 1'b0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        cyc();
        imem_rsp_valid = 1'b0;
        chk1("wait_kill_no_inst", inst_valid, 1'b0);
        chk1("wait_kill_req", imem_req_valid, 1'b1);
        chk64("wait_kill_addr", imem_addr, 64'h0000_0000_8000_0100);
        auto_mem = 1'b1;
        to_hold(64'h0000_0000_8000_0100, 32'h8000_0113); cyc();

        imem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 0) begin
                pc_ena_if = 1'b1;
                pc_if     = 64'h0000_0000_8000_0200;
            end
            cyc();
            pc_ena_if = 1'b0;
            chk1("req_redir_valid", imem_req_valid, 1'b1);
            chk64("req_redir_addr", imem_addr, 64'h0000_0000_8000_0104);
        end
        imem_req_ready = 1'b1;
        cyc();
        chk1("req_redir_wait", inst_valid, 1'b0);
        cyc();
        chk1("req_kill_no_inst", inst_valid, 1'b0);
        chk1("req_kill_req", imem_req_valid, 1'b1);
        chk64("req_kill_addr", imem_addr, 64'h0000_0000_8000_0200);
        to_hold(64'h0000_0000_8000_0200, 32'h8000_0213); cyc();
        to_hold(64'h0000_0000_8000_0204, 32'h8000_0217); cyc();
        to_hold(64'h0000_0000_8000_0208, 32'h8000_021B); cyc();
        to_hold(64'h0000_0000_8000_020C, 32'h8000_021F); cyc();
        to_hold(64'h0000_0000_8000_0210, 32'h8000_0213); cyc();

`ifdef IF_PERF_CNT_EN
        chk64("fetch_cnt", fetch_cnt, 64'd10);
        chk64("flush_cnt", flush_cnt, 64'd2);
`else
        chk64("fetch_cnt", fetch_cnt, 64'd0);
        chk64("flush_cnt", flush_cnt, 64'd0);
`endif

        to_hold(64'h0000_0000_8000_0214, 32'h8000_0217);
        pc_ena_if = 1'b1;
        pc_if     = 64'hFFFF_FFFF_FFFF_FFFC;
        cyc();
        pc_ena_if = 1'b0;
        chk1("hold_redir_drop", inst_valid, 1'b0);
        chk64("hold_redir_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        to_hold(64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_FFFF); cyc();
        chk64("pc_wrap", imem_addr, 64'h0);

        auto_mem = 1'b0;
        cyc();
        rst_n = 1'b0;
        #1;
        chk1("midrst_req_valid", imem_req_valid, 1'b0);
        chk1("midrst_inst_valid", inst_valid, 1'b0);
        chk32("midrst_inst", inst, 32'h0000_0013);
        chk64("midrst_inst_pc", inst_pc, 64'h0);
        chk64("midrst_addr", imem_addr, 64'h0000_0000_8000_0000);
        cyc();
        rst_n          = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD0_BAD0;
        cyc();
        chk1("stray_no_inst", inst_valid, 1'b0);
        chk1("stray_req", imem_req_valid, 1'b1);
        chk64("stray_addr", imem_addr, 64'h0000_0000_8000_0000);
        cyc();
        chk1("stray_no_inst2", inst_valid, 1'b0);
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b1;
        auto_mem       = 1'b1;
        to_hold(64'h0000_0000_8000_0000, 32'h8000_0013); cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, 64'h0000_0000_8000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 pc_ena_if  input  1  SHALL be the redirect request from exe_stage (jump or branch).
REQ-005 pc_if  input  64  SHALL be the redirect target, valid when pc_ena_if=1.
REQ-006 imem_req_valid  output  1  SHALL mark a fetch request; imem_addr  output  64  SHALL carry its address.
REQ-007 imem_req_ready  input  1  SHALL accept the request in the cycle where both valid and ready are 1.
REQ-008 imem_rsp_valid  input  1  and  imem_rsp_data  input  32  SHALL carry the returned instruction; at most one request SHALL be outstanding.
REQ-009 inst_valid  output  1, inst  output  32, inst_pc  output  64  SHALL present a fetched instruction to decode; inst_ready  input  1  SHALL accept it.

Function
REQ-010 FSM states SHALL be REQ (request driven), WAIT (awaiting response) and HOLD (instruction presented).
REQ-011 REQ->WAIT SHALL occur on request acceptance; WAIT->HOLD on imem_rsp_valid; HOLD->REQ on inst_valid&inst_ready.
REQ-012 While imem_req_valid=1 and not accepted, imem_addr SHALL stay stable.
REQ-013 In HOLD, inst, inst_pc and inst_valid SHALL stay stable until accepted or flushed.
REQ-014 On acceptance of a non-redirected instruction, fetch PC SHALL become inst_pc+4 (64-bit wrap-around, no overflow flag).
REQ-015 pc_ena_if in HOLD SHALL drop inst_valid the next cycle, set fetch PC to pc_if and enter REQ.
REQ-016 pc_ena_if in WAIT SHALL store pc_if and set a kill flag; the pending response SHALL be discarded (no HOLD); the FSM SHALL then enter REQ with the stored target.
REQ-017 pc_ena_if in REQ SHALL store pc_if without changing imem_addr; after acceptance the response SHALL be killed and the next request SHALL use the stored target.
REQ-018 A later redirect SHALL override an earlier stored target; redirect and inst_ready in the same HOLD cycle SHALL resolve to the redirect (instruction still counts as accepted).
REQ-019 imem_rsp_valid outside WAIT SHALL be ignored.
REQ-020 Throughput SHALL be one instruction per 3 cycles with zero-wait memory; request-to-inst_valid latency SHALL be 2 cycles.

Reset
REQ-021 With rst_n=0: state=REQ, fetch PC=RESET_PC, kill=0, inst_valid=0, inst=32'h0000_0013, inst_pc=0, imem_req_valid=0.
REQ-022 imem_req_valid SHALL first assert in the first clock cycle after rst_n rises, with imem_addr=RESET_PC.
REQ-023 Reset asserted mid-transaction SHALL abandon it; a response after reset release, before the new request is accepted, SHALL be ignored.

Configuration
REQ-024 Macro IF_PERF_CNT_EN defined: outputs fetch_cnt (64) and flush_cnt (64) SHALL count accepted instructions and redirects, reset to 0, wrapping at 2^64.
REQ-025 Macro undefined: both ports SHALL exist and be tied to 0, with no counter logic.

Structure
REQ-026 FSM state encoding, RESET_PC default and the NOP encoding 32'h0000_0013 SHALL live in the shared defines package.
REQ-027 Fetch-PC/redirect-target registers SHALL form one sub-module, if_pc_reg; the rest SHALL be flat.

Verification
REQ-028 Reset release, ready=1, 1-cycle memory -> addresses 0x8000_0000, 0x8000_0004, 0x8000_0008 with matching inst_pc.
REQ-029 HOLD with inst_ready=0 for 5 cycles -> inst/inst_pc unchanged, no new request.
REQ-030 Redirect to 0x8000_0100 in WAIT -> response dropped, next imem_addr=0x8000_0100.
REQ-031 Redirect in REQ with imem_req_ready=0 for 3 cycles -> imem_addr stable, response killed, then request to target.
REQ-032 rst_n low during WAIT, stray imem_rsp_valid after release -> inst_valid stays 0, fetch restarts at RESET_PC.
REQ-033 IF_PERF_CNT_EN: 10 accepts, 2 redirects -> fetch_cnt=10, flush_cnt=2; undefined -> both 0.
